// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: N-master to 1-slave arbiter on the sram-like req/addr_ok/data_ok bus.
// Requests are granted by fixed priority or round-robin, held stable until accepted,
// and the accepted channel IDs are queued so each response returns to its issuer in order.
module sram_like_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int OUT_DEPTH = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            m_req,
    input  logic [NUM_CH-1:0]            m_wr,
    input  logic [2*NUM_CH-1:0]          m_size,
    input  logic [ADDR_W*NUM_CH-1:0]     m_addr,
    input  logic [DATA_W*NUM_CH-1:0]     m_wdata,
    output logic [NUM_CH-1:0]            m_addr_ok,
    output logic [NUM_CH-1:0]            m_data_ok,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         s_req,
    output logic                         s_wr,
    output logic [1:0]                   s_size,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic                         s_addr_ok,
    input  logic                         s_data_ok,
    input  logic [DATA_W-1:0]            s_rdata,
    output logic [$clog2(OUT_DEPTH):0]   outstanding,
    output logic                         err
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(OUT_DEPTH);

    // Per-channel views of the packed master buses
    logic [ADDR_W-1:0] addr_arr  [NUM_CH];
    logic [DATA_W-1:0] wdata_arr [NUM_CH];
    logic [1:0]        size_arr  [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
            assign size_arr[gi]  = m_size[gi*2 +: 2];
        end
    endgenerate

    // Registered state
    logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_vld_q, lock_vld_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;
    logic            err_q, err_d;

    // In-order ID queue: channel index of every accepted, unanswered request
    logic [CH_W-1:0] id_mem [OUT_DEPTH];

    logic [CH_W-1:0] gnt;
    logic [CH_W-1:0] head_ch;
    logic [CH_W:0]   idx_sum;
    logic            found;
    logic            full;
    logic            empty;
    logic            accept;
    logic            pop;

    assign outstanding = wr_ptr_q - rd_ptr_q;
    assign full        = (outstanding == (PTR_W+1)'(OUT_DEPTH));
    assign empty       = (outstanding == '0);
    assign head_ch     = id_mem[rd_ptr_q[PTR_W-1:0]];

    // Grant selection: a locked channel keeps the bus, otherwise fixed priority or round-robin
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        idx_sum = '0;
        if (lock_vld_q) begin
            gnt = lock_ch_q;
        end else if (PRIO_MODE == 0) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (m_req[k]) begin
                    gnt = CH_W'(k);
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
                if (idx_sum >= (CH_W+1)'(NUM_CH)) begin
                    idx_sum = idx_sum - (CH_W+1)'(NUM_CH);
                end
                if (!found && m_req[idx_sum[CH_W-1:0]]) begin
                    gnt   = idx_sum[CH_W-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    // Request path: zero-latency mux from the granted channel; held off while the ID queue is full
    assign s_req   = resetn & m_req[gnt] & ~full;
    assign s_wr    = m_wr[gnt];
    assign s_size  = size_arr[gnt];
    assign s_addr  = addr_arr[gnt];
    assign s_wdata = wdata_arr[gnt];

    assign accept  = s_req & s_addr_ok;
    assign pop     = s_data_ok & ~empty;
    assign m_rdata = s_rdata;
    assign err     = err_q;

    // Handshake fan-out: one-hot accept to the granted master, one-hot response to the queue head
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (accept) begin
            m_addr_ok[gnt] = 1'b1;
        end
        if (pop) begin
            m_data_ok[head_ch] = 1'b1;
        end
    end

    // Next-state: queue pointers, round-robin pointer, hold lock and sticky error
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, accept};
        rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        err_d      = err_q | (s_data_ok & empty);
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_ch_d  = lock_ch_q;
        if (accept) begin
            rr_ptr_d   = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
            lock_vld_d = 1'b0;
        end else if (s_req) begin
            // Presented but not accepted: the address must stay on the bus
            lock_vld_d = 1'b1;
            lock_ch_d  = gnt;
        end else if (lock_vld_q && !m_req[lock_ch_q]) begin
            // Locked master withdrew its request; release so others are not blocked forever
            lock_vld_d = 1'b0;
        end
    end

    // ID queue storage; contents are only meaningful between the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            id_mem[wr_ptr_q[PTR_W-1:0]] <= gnt;
        end
    end

    // Control state with asynchronous reset; reset discards every pending response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_ch_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_ch_q  <= lock_ch_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a fixed-priority and a round-robin instance
// share the same stimulus, each checked against hand-computed expectations.
module tb_sram_like_arbiter;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int OD  = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NCH-1:0]  m_req;
    logic [NCH-1:0]  m_wr;
    logic [2*NCH-1:0] m_size;
    logic [AW*NCH-1:0] m_addr;
    logic [DW*NCH-1:0] m_wdata;
    logic            s_addr_ok;
    logic            s_data_ok;
    logic [DW-1:0]   s_rdata;

    logic [NCH-1:0]  f_m_addr_ok, f_m_data_ok, r_m_addr_ok, r_m_data_ok;
    logic [DW-1:0]   f_m_rdata, r_m_rdata;
    logic            f_s_req, f_s_wr, r_s_req, r_s_wr;
    logic [1:0]      f_s_size, r_s_size;
    logic [AW-1:0]   f_s_addr, r_s_addr;
    logic [DW-1:0]   f_s_wdata, r_s_wdata;
    logic [2:0]      f_outstanding, r_outstanding;
    logic            f_err, r_err;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .OUT_DEPTH(OD), .PRIO_MODE(0)) u_fix (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(f_m_addr_ok), .m_data_ok(f_m_data_ok),
        .m_rdata(f_m_rdata), .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size),
        .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .s_rdata(s_rdata), .outstanding(f_outstanding), .err(f_err)
    );

    sram_like_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .OUT_DEPTH(OD), .PRIO_MODE(1)) u_rr (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(r_m_addr_ok), .m_data_ok(r_m_data_ok),
        .m_rdata(r_m_rdata), .s_req(r_s_req), .s_wr(r_s_wr), .s_size(r_s_size),
        .s_addr(r_s_addr), .s_wdata(r_s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .s_rdata(s_rdata), .outstanding(r_outstanding), .err(r_err)
    );

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus and log it
    task automatic set_in(input logic [1:0] req, input logic aok, input logic dok, input logic [31:0] rd);
        m_req     = req;
        s_addr_ok = aok;
        s_data_ok = dok;
        s_rdata   = rd;
        $display("t=%0t m_req=%b s_addr_ok=%b s_data_ok=%b s_rdata=%h", $time, req, aok, dok, rd);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_in(2'b11, 1'b1, 1'b1, 32'h0);
        #3;
        vectors++; if (f_s_req !== 1'b0) begin fails++; $display("FAIL reset_fix_s_req: got %b want 0", f_s_req); end
        vectors++; if (r_s_req !== 1'b0) begin fails++; $display("FAIL reset_rr_s_req: got %b want 0", r_s_req); end
        vectors++; if (f_outstanding !== 3'd0) begin fails++; $display("FAIL reset_outstanding: got %0d want 0", f_outstanding); end
        vectors++; if (f_m_addr_ok !== 2'b00) begin fails++; $display("FAIL reset_addr_ok: got %b want 00", f_m_addr_ok); end
        vectors++; if (f_m_data_ok !== 2'b00) begin fails++; $display("FAIL reset_data_ok: got %b want 00", f_m_data_ok); end
        vectors++; if (f_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", f_err); end
        do_reset();
    endtask

    task automatic test_accept_fixed_rr();
        logic [1:0]  exp_rr;
        logic [31:0] exp_ra;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            set_in(2'b11, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            exp_rr = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_ra = (k % 2 == 0) ? 32'h1000 : 32'h2000;
            vectors++; if (f_m_addr_ok !== 2'b01) begin fails++; $display("FAIL fix_addr_ok[%0d]: got %b want 01", k, f_m_addr_ok); end
            vectors++; if (f_s_addr !== 32'h1000) begin fails++; $display("FAIL fix_s_addr[%0d]: got %h want 00001000", k, f_s_addr); end
            vectors++; if (f_s_wr !== 1'b1) begin fails++; $display("FAIL fix_s_wr[%0d]: got %b want 1", k, f_s_wr); end
            vectors++; if (f_s_size !== 2'd2) begin fails++; $display("FAIL fix_s_size[%0d]: got %0d want 2", k, f_s_size); end
            vectors++; if (f_s_wdata !== 32'hDEAD0000) begin fails++; $display("FAIL fix_s_wdata[%0d]: got %h want dead0000", k, f_s_wdata); end
            vectors++; if (f_outstanding !== 3'(k)) begin fails++; $display("FAIL fix_outstanding[%0d]: got %0d want %0d", k, f_outstanding, k); end
            vectors++; if (r_m_addr_ok !== exp_rr) begin fails++; $display("FAIL rr_addr_ok[%0d]: got %b want %b", k, r_m_addr_ok, exp_rr); end
            vectors++; if (r_s_addr !== exp_ra) begin fails++; $display("FAIL rr_s_addr[%0d]: got %h want %h", k, r_s_addr, exp_ra); end
        end
        next_cycle();
        set_in(2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_s_req !== 1'b0) begin fails++; $display("FAIL full_fix_s_req: got %b want 0", f_s_req); end
        vectors++; if (r_s_req !== 1'b0) begin fails++; $display("FAIL full_rr_s_req: got %b want 0", r_s_req); end
        vectors++; if (f_outstanding !== 3'd4) begin fails++; $display("FAIL full_outstanding: got %0d want 4", f_outstanding); end
        vectors++; if (f_m_addr_ok !== 2'b00) begin fails++; $display("FAIL full_addr_ok: got %b want 00", f_m_addr_ok); end
    endtask

    task automatic test_rr_responses();
        logic [1:0]  exp_rr;
        logic [31:0] exp_d;
        for (int r = 0; r < 4; r++) begin
            next_cycle();
            exp_d = 32'hA0 + 32'(r);
            set_in(2'b00, 1'b0, 1'b1, exp_d);
            @(negedge clk);
            exp_rr = (r % 2 == 0) ? 2'b01 : 2'b10;
            vectors++; if (r_m_data_ok !== exp_rr) begin fails++; $display("FAIL rr_data_ok[%0d]: got %b want %b", r, r_m_data_ok, exp_rr); end
            vectors++; if (r_m_rdata !== exp_d) begin fails++; $display("FAIL rr_rdata[%0d]: got %h want %h", r, r_m_rdata, exp_d); end
            vectors++; if (f_m_data_ok !== 2'b01) begin fails++; $display("FAIL fix_data_ok[%0d]: got %b want 01", r, f_m_data_ok); end
            vectors++; if (r_outstanding !== 3'(4 - r)) begin fails++; $display("FAIL rr_outstanding[%0d]: got %0d want %0d", r, r_outstanding, 4 - r); end
        end
        next_cycle();
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (r_outstanding !== 3'd0) begin fails++; $display("FAIL rr_drained: got %0d want 0", r_outstanding); end
        vectors++; if (f_err !== 1'b0) begin fails++; $display("FAIL no_spurious_err: got %b want 0", f_err); end
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            set_in((c >= 2) ? 2'b11 : 2'b10, (c == 3) ? 1'b1 : 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            vectors++; if (f_s_addr !== 32'h2000) begin fails++; $display("FAIL lock_s_addr[%0d]: got %h want 00002000", c, f_s_addr); end
            if (c < 3) begin
                vectors++; if (f_m_addr_ok !== 2'b00) begin fails++; $display("FAIL lock_wait_addr_ok[%0d]: got %b want 00", c, f_m_addr_ok); end
                vectors++; if (f_s_req !== 1'b1) begin fails++; $display("FAIL lock_s_req[%0d]: got %b want 1", c, f_s_req); end
            end else begin
                vectors++; if (f_m_addr_ok !== 2'b10) begin fails++; $display("FAIL lock_accept: got %b want 10", f_m_addr_ok); end
            end
        end
        next_cycle();
        set_in(2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_m_addr_ok !== 2'b01) begin fails++; $display("FAIL lock_after_addr_ok: got %b want 01", f_m_addr_ok); end
        vectors++; if (f_s_addr !== 32'h1000) begin fails++; $display("FAIL lock_after_s_addr: got %h want 00001000", f_s_addr); end
    endtask

    task automatic test_full();
        do_reset();
        repeat (4) begin
            next_cycle();
            set_in(2'b01, 1'b1, 1'b0, 32'h0);
        end
        next_cycle();
        set_in(2'b01, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_outstanding !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", f_outstanding); end
        vectors++; if (f_s_req !== 1'b0) begin fails++; $display("FAIL full_block: got %b want 0", f_s_req); end
        next_cycle();
        set_in(2'b01, 1'b0, 1'b1, 32'h55);
        @(negedge clk);
        vectors++; if (f_m_data_ok !== 2'b01) begin fails++; $display("FAIL full_pop_data_ok: got %b want 01", f_m_data_ok); end
        vectors++; if (f_s_req !== 1'b0) begin fails++; $display("FAIL full_pop_s_req: got %b want 0", f_s_req); end
        next_cycle();
        set_in(2'b01, 1'b1, 1'b1, 32'h66);
        @(negedge clk);
        vectors++; if (f_outstanding !== 3'd3) begin fails++; $display("FAIL after_pop_count: got %0d want 3", f_outstanding); end
        vectors++; if (f_s_req !== 1'b1) begin fails++; $display("FAIL after_pop_s_req: got %b want 1", f_s_req); end
        vectors++; if (f_m_addr_ok !== 2'b01) begin fails++; $display("FAIL pushpop_addr_ok: got %b want 01", f_m_addr_ok); end
        vectors++; if (f_m_data_ok !== 2'b01) begin fails++; $display("FAIL pushpop_data_ok: got %b want 01", f_m_data_ok); end
        next_cycle();
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_outstanding !== 3'd3) begin fails++; $display("FAIL pushpop_count: got %0d want 3", f_outstanding); end
    endtask

    task automatic test_err_reset();
        do_reset();
        next_cycle();
        set_in(2'b00, 1'b0, 1'b1, 32'h77);
        @(negedge clk);
        vectors++; if (f_m_data_ok !== 2'b00) begin fails++; $display("FAIL empty_fix_data_ok: got %b want 00", f_m_data_ok); end
        vectors++; if (r_m_data_ok !== 2'b00) begin fails++; $display("FAIL empty_rr_data_ok: got %b want 00", r_m_data_ok); end
        next_cycle();
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_err !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", f_err); end
        next_cycle();
        @(negedge clk);
        vectors++; if (f_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", f_err); end
        repeat (2) begin
            next_cycle();
            set_in(2'b01, 1'b1, 1'b0, 32'h0);
        end
        next_cycle();
        set_in(2'b01, 1'b0, 1'b0, 32'h0);
        #1;
        vectors++; if (f_outstanding !== 3'd2) begin fails++; $display("FAIL pre_reset_count: got %0d want 2", f_outstanding); end
        vectors++; if (f_s_req !== 1'b1) begin fails++; $display("FAIL pre_reset_s_req: got %b want 1", f_s_req); end
        #1 resetn = 1'b0;
        #1;
        vectors++; if (f_outstanding !== 3'd0) begin fails++; $display("FAIL async_reset_count: got %0d want 0", f_outstanding); end
        vectors++; if (f_s_req !== 1'b0) begin fails++; $display("FAIL async_reset_s_req: got %b want 0", f_s_req); end
        vectors++; if (r_s_req !== 1'b0) begin fails++; $display("FAIL async_reset_rr_s_req: got %b want 0", r_s_req); end
        next_cycle();
        resetn = 1'b1;
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", f_err); end
        vectors++; if (f_outstanding !== 3'd0) begin fails++; $display("FAIL post_reset_count: got %0d want 0", f_outstanding); end
        next_cycle();
        set_in(2'b00, 1'b0, 1'b1, 32'h88);
        @(negedge clk);
        vectors++; if (f_m_data_ok !== 2'b00) begin fails++; $display("FAIL stale_resp_data_ok: got %b want 00", f_m_data_ok); end
        next_cycle();
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_err !== 1'b1) begin fails++; $display("FAIL stale_resp_err: got %b want 1", f_err); end
    endtask

    task automatic test_withdraw();
        do_reset();
        next_cycle();
        set_in(2'b10, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_s_addr !== 32'h2000) begin fails++; $display("FAIL wd_s_addr: got %h want 00002000", f_s_addr); end
        next_cycle();
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_s_req !== 1'b0) begin fails++; $display("FAIL wd_drop_s_req: got %b want 0", f_s_req); end
        next_cycle();
        set_in(2'b01, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        vectors++; if (f_s_req !== 1'b1) begin fails++; $display("FAIL wd_release_s_req: got %b want 1", f_s_req); end
        vectors++; if (f_s_addr !== 32'h1000) begin fails++; $display("FAIL wd_release_s_addr: got %h want 00001000", f_s_addr); end
    endtask

    initial begin
        m_addr  = {32'h0000_2000, 32'h0000_1000};
        m_wdata = {32'hBEEF_0001, 32'hDEAD_0000};
        m_wr    = 2'b01;
        m_size  = {2'd1, 2'd2};
        test_reset();
        test_accept_fixed_rr();
        test_rr_responses();
        test_lock();
        test_full();
        test_err_reset();
        test_withdraw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
